// File: rtl/wb_stage_if.sv
// Writeback stage bundle: M/WB entry handshake, memory load response,
// register-file write port, pending-load tag and retire counter.
//   master : drives the M/WB entry and the memory response, observes the rest
//   slave  : the writeback stage itself
interface wb_stage_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
);
    // M/WB entry
    logic             in_valid;
    logic             in_ready;
    logic             in_reg_wr;
    logic [4:0]       in_reg_wnum;
    logic [1:0]       in_src;
    logic [XLEN-1:0]  in_aluresult;
    logic [XLEN-1:0]  in_pc_plus4;
    logic [XLEN-1:0]  in_csr_rdata;
    logic [2:0]       in_funct3;
    // Memory load response
    logic             mem_rvalid;
    logic [XLEN-1:0]  mem_rdata;
    // Register-file write / forwarding
    logic             reg_wen;
    logic [4:0]       reg_wnum;
    logic [XLEN-1:0]  rwdata;
    // Hazard tag and retire counter
    logic             pend_valid;
    logic [4:0]       pend_num;
    logic [CNT_W-1:0] retire_cnt;

    modport master (
        output in_valid, in_reg_wr, in_reg_wnum, in_src, in_aluresult,
               in_pc_plus4, in_csr_rdata, in_funct3, mem_rvalid, mem_rdata,
        input  in_ready, reg_wen, reg_wnum, rwdata, pend_valid, pend_num,
               retire_cnt
    );

    modport slave (
        input  in_valid, in_reg_wr, in_reg_wnum, in_src, in_aluresult,
               in_pc_plus4, in_csr_rdata, in_funct3, mem_rvalid, mem_rdata,
        output in_ready, reg_wen, reg_wnum, rwdata, pend_valid, pend_num,
               retire_cnt
    );
endinterface

// File: rtl/wb_stage.sv
// Registered writeback stage for the rv32/rv64 core.
// Accepts one retiring instruction per handshake, selects ALU / load / PC+4 /
// CSR as the result, waits for the memory response on loads, aligns and
// extends the loaded data, issues a one-cycle register-file write, exposes a
// pending-load tag for hazard logic and counts retired instructions.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - wb_stage_if slave modport (entry handshake, memory response,
//          register-file write, pending tag, retire counter)
module wb_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32,
    parameter int unsigned OFF_W = $clog2(XLEN / 8)
) (
    input logic        clk,
    input logic        rst,
    wb_stage_if.slave  bus
);
    localparam logic [1:0] SrcAlu  = 2'd0;
    localparam logic [1:0] SrcLoad = 2'd1;
    localparam logic [1:0] SrcPc4  = 2'd2;

    typedef enum logic [0:0] {StIdle, StWaitMem} state_e;

    state_e           state_q, state_d;
    logic             ld_wr_q, ld_wr_d;
    logic [4:0]       ld_wnum_q, ld_wnum_d;
    logic [2:0]       ld_funct3_q, ld_funct3_d;
    logic [OFF_W-1:0] ld_off_q, ld_off_d;
    logic             reg_wen_q, reg_wen_d;
    logic [4:0]       reg_wnum_q, reg_wnum_d;
    logic [XLEN-1:0]  rwdata_q, rwdata_d;
    logic [CNT_W-1:0] retire_q, retire_d;

    logic [XLEN-1:0]  sel_data;
    logic [XLEN-1:0]  load_data;
    logic [OFF_W-1:0] off_h, off_w;

    // Non-load result mux
    always_comb begin
        sel_data = bus.in_aluresult;
        if (bus.in_src == SrcPc4) begin
            sel_data = bus.in_pc_plus4;
        end else if (bus.in_src != SrcAlu) begin
            sel_data = bus.in_csr_rdata;
        end
    end

    // Misaligned halves/words are treated as aligned down to their natural boundary
    assign off_h = ld_off_q & ~OFF_W'(1);
    assign off_w = ld_off_q & ~OFF_W'(3);

    always_comb begin
        load_data = '0;
        case (ld_funct3_q)
            3'b000: load_data = XLEN'(signed'(bus.mem_rdata[{ld_off_q, 3'b000} +: 8]));
            3'b100: load_data = XLEN'(bus.mem_rdata[{ld_off_q, 3'b000} +: 8]);
            3'b001: load_data = XLEN'(signed'(bus.mem_rdata[{off_h, 3'b000} +: 16]));
            3'b101: load_data = XLEN'(bus.mem_rdata[{off_h, 3'b000} +: 16]);
            3'b010: load_data = XLEN'(signed'(bus.mem_rdata[{off_w, 3'b000} +: 32]));
            3'b110: begin
                if (XLEN == 64) load_data = XLEN'(bus.mem_rdata[{off_w, 3'b000} +: 32]);
            end
            3'b011: begin
                if (XLEN == 64) load_data = bus.mem_rdata;
            end
            default: load_data = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ld_wr_d     = ld_wr_q;
        ld_wnum_d   = ld_wnum_q;
        ld_funct3_d = ld_funct3_q;
        ld_off_d    = ld_off_q;
        reg_wen_d   = 1'b0;
        reg_wnum_d  = reg_wnum_q;
        rwdata_d    = rwdata_q;
        retire_d    = retire_q;

        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    if (bus.in_src == SrcLoad) begin
                        ld_wr_d     = bus.in_reg_wr;
                        ld_wnum_d   = bus.in_reg_wnum;
                        ld_funct3_d = bus.in_funct3;
                        ld_off_d    = bus.in_aluresult[OFF_W-1:0];
                        state_d     = StWaitMem;
                    end else begin
                        retire_d = retire_q + CNT_W'(1);
                        // x0 writes retire but leave the write port untouched
                        if (bus.in_reg_wr && (bus.in_reg_wnum != 5'd0)) begin
                            reg_wen_d  = 1'b1;
                            reg_wnum_d = bus.in_reg_wnum;
                            rwdata_d   = sel_data;
                        end
                    end
                end
            end
            StWaitMem: begin
                if (bus.mem_rvalid) begin
                    retire_d = retire_q + CNT_W'(1);
                    state_d  = StIdle;
                    if (ld_wr_q && (ld_wnum_q != 5'd0)) begin
                        reg_wen_d  = 1'b1;
                        reg_wnum_d = ld_wnum_q;
                        rwdata_d   = load_data;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ld_wr_q     <= 1'b0;
            ld_wnum_q   <= '0;
            ld_funct3_q <= '0;
            ld_off_q    <= '0;
            reg_wen_q   <= 1'b0;
            reg_wnum_q  <= '0;
            rwdata_q    <= '0;
            retire_q    <= '0;
        end else begin
            state_q     <= state_d;
            ld_wr_q     <= ld_wr_d;
            ld_wnum_q   <= ld_wnum_d;
            ld_funct3_q <= ld_funct3_d;
            ld_off_q    <= ld_off_d;
            reg_wen_q   <= reg_wen_d;
            reg_wnum_q  <= reg_wnum_d;
            rwdata_q    <= rwdata_d;
            retire_q    <= retire_d;
        end
    end

    assign bus.in_ready   = (state_q == StIdle);
    assign bus.reg_wen    = reg_wen_q;
    assign bus.reg_wnum   = reg_wnum_q;
    assign bus.rwdata     = rwdata_q;
    // Tag drops automatically once the completion moves the state back to idle
    assign bus.pend_valid = (state_q == StWaitMem) && ld_wr_q && (ld_wnum_q != 5'd0);
    assign bus.pend_num   = ld_wnum_q;
    assign bus.retire_cnt = retire_q;
endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    wb_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Architectural expectations: last written register/data, retired count
    logic [31:0] exp_cnt;
    logic [31:0] exp_data;
    logic [4:0]  exp_wnum;

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int unsigned off,
                                             input logic [31:0] d);
        int unsigned b, h;
        b = (d >> (8 * off)) % 256;
        h = (d >> (16 * (off / 2))) % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd5:    return h;
            3'd2:    return d;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_pick(input int src, input logic [31:0] alu,
                                             input logic [31:0] pc4, input logic [31:0] csr);
        if (src == 2) return pc4;
        if (src == 3) return csr;
        return alu;
    endfunction

    task automatic scramble_entry();
        bus.in_reg_wr    = 1'($urandom);
        bus.in_reg_wnum  = 5'($urandom);
        bus.in_src       = 2'($urandom);
        bus.in_aluresult = $urandom;
        bus.in_pc_plus4  = $urandom;
        bus.in_csr_rdata = $urandom;
        bus.in_funct3    = 3'($urandom);
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.in_valid   = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = $urandom;
        scramble_entry();
        repeat (2) @(negedge clk);
        bus.in_valid   = 1'b0;
        bus.mem_rvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.in_ready !== 1'b1) begin errors++;
            $display("FAIL reset in_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.reg_wen !== 1'b0) begin errors++;
            $display("FAIL reset reg_wen: got %b want 0", bus.reg_wen); end
        checks++; if (bus.reg_wnum !== 5'd0) begin errors++;
            $display("FAIL reset reg_wnum: got %0d want 0", bus.reg_wnum); end
        checks++; if (bus.rwdata !== 32'd0) begin errors++;
            $display("FAIL reset rwdata: got %h want 0", bus.rwdata); end
        checks++; if (bus.pend_valid !== 1'b0 || bus.pend_num !== 5'd0) begin errors++;
            $display("FAIL reset pend: got %b/%0d want 0/0", bus.pend_valid, bus.pend_num); end
        checks++; if (bus.retire_cnt !== 32'd0) begin errors++;
            $display("FAIL reset retire_cnt: got %0d want 0", bus.retire_cnt); end
        exp_cnt = 0; exp_data = 0; exp_wnum = 0;
    endtask

    task automatic test_alu(input string name, input logic wr, input logic [4:0] rd,
                            input int src, input logic [31:0] alu, input logic [31:0] pc4,
                            input logic [31:0] csr);
        logic ewen;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_reg_wr = wr; bus.in_reg_wnum = rd; bus.in_src = 2'(src);
        bus.in_aluresult = alu; bus.in_pc_plus4 = pc4; bus.in_csr_rdata = csr;
        bus.in_funct3 = 3'($urandom);
        @(negedge clk);
        bus.in_valid = 1'b0;
        scramble_entry();
        exp_cnt++;
        ewen = wr && (rd != 0);
        if (ewen) begin exp_wnum = rd; exp_data = ref_pick(src, alu, pc4, csr); end
        checks++; if (bus.reg_wen !== ewen) begin errors++;
            $display("FAIL %s reg_wen: got %b want %b", name, bus.reg_wen, ewen); end
        checks++; if (bus.reg_wnum !== exp_wnum || bus.rwdata !== exp_data) begin errors++;
            $display("FAIL %s write: got x%0d=%h want x%0d=%h", name, bus.reg_wnum,
                     bus.rwdata, exp_wnum, exp_data); end
        checks++; if (bus.retire_cnt !== exp_cnt) begin errors++;
            $display("FAIL %s retire_cnt: got %0d want %0d", name, bus.retire_cnt, exp_cnt); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++;
            $display("FAIL %s in_ready: got %b want 1", name, bus.in_ready); end
        @(negedge clk);
        checks++; if (bus.reg_wen !== 1'b0 || bus.rwdata !== exp_data) begin errors++;
            $display("FAIL %s after: got wen=%b data=%h want wen=0 data=%h", name,
                     bus.reg_wen, bus.rwdata, exp_data); end
    endtask

    task automatic test_back_to_back();
        int          srcs[4] = '{0, 2, 3, 0};
        logic [4:0]  rds[4];
        logic [31:0] alus[4], pcs[4], csrs[4];
        for (int i = 0; i < 4; i++) begin
            rds[i] = 5'($urandom_range(1, 31));
            alus[i] = $urandom; pcs[i] = $urandom; csrs[i] = $urandom;
        end
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                exp_cnt++; exp_wnum = rds[i-1];
                exp_data = ref_pick(srcs[i-1], alus[i-1], pcs[i-1], csrs[i-1]);
                checks++;
                if (bus.reg_wen !== 1'b1 || bus.reg_wnum !== exp_wnum ||
                    bus.rwdata !== exp_data || bus.retire_cnt !== exp_cnt) begin
                    errors++;
                    $display("FAIL b2b[%0d]: got wen=%b x%0d=%h cnt=%0d want 1 x%0d=%h cnt=%0d",
                             i - 1, bus.reg_wen, bus.reg_wnum, bus.rwdata, bus.retire_cnt,
                             exp_wnum, exp_data, exp_cnt);
                end
                checks++; if (bus.in_ready !== 1'b1) begin errors++;
                    $display("FAIL b2b[%0d] in_ready: got %b want 1", i - 1, bus.in_ready); end
            end
            if (i < 4) begin
                bus.in_valid = 1'b1; bus.in_reg_wr = 1'b1; bus.in_reg_wnum = rds[i];
                bus.in_src = 2'(srcs[i]); bus.in_aluresult = alus[i];
                bus.in_pc_plus4 = pcs[i]; bus.in_csr_rdata = csrs[i];
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++; if (bus.reg_wen !== 1'b0) begin errors++;
            $display("FAIL b2b tail reg_wen: got %b want 0", bus.reg_wen); end
    endtask

    task automatic test_load(input string name, input logic wr, input logic [4:0] rd,
                             input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] data, input int delay);
        logic epend, ewen;
        epend = wr && (rd != 0);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_reg_wr = wr; bus.in_reg_wnum = rd; bus.in_src = 2'd1;
        bus.in_aluresult = addr; bus.in_funct3 = f3;
        bus.in_pc_plus4 = $urandom; bus.in_csr_rdata = $urandom;
        for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            // Entry fields change and valid is offered while busy; none may be taken
            scramble_entry();
            bus.in_valid = 1'b1;
            checks++; if (bus.in_ready !== 1'b0 || bus.reg_wen !== 1'b0) begin errors++;
                $display("FAIL %s wait%0d: got ready=%b wen=%b want 0/0", name, k,
                         bus.in_ready, bus.reg_wen); end
            checks++; if (bus.pend_valid !== epend || bus.pend_num !== rd) begin errors++;
                $display("FAIL %s pend%0d: got %b/%0d want %b/%0d", name, k, bus.pend_valid,
                         bus.pend_num, epend, rd); end
            checks++; if (bus.retire_cnt !== exp_cnt) begin errors++;
                $display("FAIL %s wait retire_cnt: got %0d want %0d", name, bus.retire_cnt,
                         exp_cnt); end
            bus.mem_rvalid = (k == delay - 1);
            bus.mem_rdata  = (k == delay - 1) ? data : $urandom;
        end
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        bus.in_valid   = 1'b0;
        bus.mem_rdata  = $urandom;
        exp_cnt++;
        ewen = epend;
        if (ewen) begin exp_wnum = rd; exp_data = ref_load(f3, addr % 4, data); end
        checks++; if (bus.reg_wen !== ewen) begin errors++;
            $display("FAIL %s reg_wen: got %b want %b", name, bus.reg_wen, ewen); end
        checks++; if (bus.reg_wnum !== exp_wnum || bus.rwdata !== exp_data) begin errors++;
            $display("FAIL %s data: got x%0d=%h want x%0d=%h (f3=%0d off=%0d mem=%h)", name,
                     bus.reg_wnum, bus.rwdata, exp_wnum, exp_data, f3, addr % 4, data); end
        checks++; if (bus.retire_cnt !== exp_cnt || bus.pend_valid !== 1'b0 ||
                      bus.in_ready !== 1'b1) begin errors++;
            $display("FAIL %s done: got cnt=%0d pend=%b ready=%b want %0d/0/1", name,
                     bus.retire_cnt, bus.pend_valid, bus.in_ready, exp_cnt); end
        @(negedge clk);
        checks++; if (bus.reg_wen !== 1'b0) begin errors++;
            $display("FAIL %s after reg_wen: got %b want 0", name, bus.reg_wen); end
    endtask

    task automatic test_idle_rvalid();
        @(negedge clk);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = $urandom;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        @(negedge clk);
        checks++; if (bus.reg_wen !== 1'b0 || bus.retire_cnt !== exp_cnt ||
                      bus.rwdata !== exp_data) begin errors++;
            $display("FAIL idle_rvalid: got wen=%b cnt=%0d data=%h want 0/%0d/%h",
                     bus.reg_wen, bus.retire_cnt, bus.rwdata, exp_cnt, exp_data); end
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_reg_wr = 1'b1; bus.in_reg_wnum = 5'd7;
        bus.in_src = 2'd1; bus.in_funct3 = 3'd2; bus.in_aluresult = 32'h100;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.pend_valid !== 1'b1 || bus.in_ready !== 1'b0) begin errors++;
            $display("FAIL rst_wait pre: got pend=%b ready=%b want 1/0", bus.pend_valid,
                     bus.in_ready); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEAD_BEEF;
        exp_cnt = 0; exp_data = 0; exp_wnum = 0;
        checks++; if (bus.in_ready !== 1'b1 || bus.pend_valid !== 1'b0 ||
                      bus.retire_cnt !== 32'd0) begin errors++;
            $display("FAIL rst_wait post: got ready=%b pend=%b cnt=%0d want 1/0/0",
                     bus.in_ready, bus.pend_valid, bus.retire_cnt); end
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        checks++; if (bus.reg_wen !== 1'b0 || bus.retire_cnt !== 32'd0 ||
                      bus.rwdata !== 32'd0) begin errors++;
            $display("FAIL rst_wait rvalid: got wen=%b cnt=%0d data=%h want 0/0/0",
                     bus.reg_wen, bus.retire_cnt, bus.rwdata); end
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            int          src;
            logic        wr;
            logic [4:0]  rd;
            src = int'($urandom_range(0, 3));
            wr  = ($urandom_range(0, 7) != 0);
            rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            if (src == 1) begin
                test_load("rnd_load", wr, rd, 3'($urandom), $urandom, $urandom,
                          int'($urandom_range(1, 4)));
            end else begin
                test_alu("rnd_alu", wr, rd, src, $urandom, $urandom, $urandom);
            end
            if ($urandom_range(0, 9) == 0) test_idle_rvalid();
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        scramble_entry();
        test_reset();
        test_alu("alu_rd5", 1'b1, 5'd5, 0, 32'h1234, 32'h0, 32'h0);
        test_back_to_back();
        test_load("lb_off3", 1'b1, 5'd9, 3'd0, 32'h1003, 32'h80FF_FF01, 3);
        test_load("lhu_off2", 1'b1, 5'd10, 3'd5, 32'h2002, 32'hBEEF_0000, 1);
        test_load("lh_off2", 1'b1, 5'd11, 3'd1, 32'h2002, 32'hBEEF_0000, 2);
        test_load("lw_misal", 1'b1, 5'd12, 3'd2, 32'h3003, 32'hCAFE_F00D, 1);
        test_load("bad_f3", 1'b1, 5'd13, 3'd7, 32'h0, 32'h1234_5678, 1);
        test_load("lb_x0", 1'b1, 5'd0, 3'd0, 32'h0, 32'hFFFF_FFFF, 2);
        test_alu("alu_x0", 1'b1, 5'd0, 0, 32'h5555, 32'h0, 32'h0);
        test_alu("alu_nowr", 1'b0, 5'd4, 3, 32'h1, 32'h2, 32'h3);
        test_idle_rvalid();
        test_reset_in_wait();
        test_random(200);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Registered, parametrised writeback stage for the rv32/rv64 core. It accepts one retiring instruction per handshake from the M/WB boundary and selects the result source: ALU, load, PC+4 or CSR. For loads it waits for a possibly delayed memory response, then aligns and sign- or zero-extends the returned data. It issues a single-cycle register-file write, publishes a pending-load tag for hazard logic, and counts retired instructions.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
CNT_W, 32, width of the retire counter.
OFF_W, $clog2(XLEN/8), byte-offset width (derived; do not override).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  M/WB entry valid
in_ready  out  1  stage can accept an entry
in_reg_wr  in  1  instruction writes rd
in_reg_wnum  in  5  rd index
in_src  in  2  result source: 0 ALU, 1 LOAD, 2 PC+4, 3 CSR
in_aluresult  in  XLEN  ALU result; also used as load address
in_pc_plus4  in  XLEN  link value
in_csr_rdata  in  XLEN  CSR old value
in_funct3  in  3  load size/sign
mem_rvalid  in  1  load data valid
mem_rdata  in  XLEN  naturally aligned memory word/dword
reg_wen  out  1  register-file write strobe
reg_wnum  out  5  register-file write index
rwdata  out  XLEN  register-file write data (also forward data)
pend_valid  out  1  a load is outstanding
pend_num  out  5  rd of the outstanding load
retire_cnt  out  CNT_W  instructions completed

Behaviour:
- Reset values: state IDLE, in_ready 1, reg_wen 0, reg_wnum 0, rwdata 0, pend_valid 0, pend_num 0, retire_cnt 0. Reset in WAIT_MEM abandons the load with no write and no retire.
- States: IDLE and WAIT_MEM. in_ready = (state == IDLE); combinational from state only.
- IDLE, accept (in_valid & in_ready) with in_src != 1: in the next cycle, reg_wen = in_reg_wr & (in_reg_wnum != 0) for exactly 1 cycle. reg_wnum and rwdata hold the selected source. retire_cnt increments in that same next cycle. Stay in IDLE, so back-to-back accepts give 1/cycle throughput.
- IDLE, accept with in_src == 1: latch reg_wr, wnum, funct3 and in_aluresult[OFF_W-1:0]. Go to WAIT_MEM. pend_valid = in_reg_wr & (wnum != 0) and pend_num = wnum from the next cycle.
- WAIT_MEM: mem_rvalid is sampled only in this state; the earliest sample is the cycle after accept. On mem_rvalid, the extracted data is written next cycle with the same rules as above; retire_cnt increments; pend_valid clears in that same cycle; go to IDLE.
- mem_rvalid in IDLE is ignored.
- reg_wen is 0 in every cycle without a completion. rwdata/reg_wnum hold their last value when reg_wen = 0.
- Load extraction, off = latched offset:
  - 000 LB: sign-extend byte[off].
  - 100 LBU: zero-extend byte[off].
  - 001 LH: sign-extend half at off with bit0 forced to 0.
  - 101 LHU: zero-extend half at off with bit0 forced to 0.
  - 010 LW: sign-extend word at off with low 2 bits forced to 0.
  - XLEN=64 only: 110 LWU zero-extends; 011 LD uses the full dword.
  - Any other funct3: result 0.
- retire_cnt wraps modulo 2^CNT_W. It counts completions with in_reg_wr = 0 or rd = x0.
- Writes to x0 retire but never assert reg_wen. Loads to x0 still wait for mem_rvalid.

Test Plan:
- ALU op, rd=5, aluresult=0x1234, accepted at cycle t -> at t+1: reg_wen=1, reg_wnum=5, rwdata=0x1234, retire_cnt=1. At t+2: reg_wen=0.
- Four back-to-back accepts with src 0,2,3,0 -> writes on 4 consecutive cycles with ALU, pc_plus4, CSR, ALU data; in_ready stays 1.
- LB, addr_lo=3, mem_rdata=0x80FF_FF01, mem_rvalid 3 cycles after accept -> in_ready=0 and pend_valid=1 for 3 cycles; then rwdata=0xFFFF_FF80, reg_wen pulses once.
- LHU at offset 2 on 0xBEEF_0000 -> 0x0000_BEEF. LH on the same data -> 0xFFFF_BEEF.
- ALU write to rd=0 -> reg_wen stays 0 and retire_cnt increments. mem_rvalid pulsed in IDLE -> no write.
- rst asserted in WAIT_MEM, then mem_rvalid -> no write, pend_valid=0, retire_cnt=0, in_ready=1 after reset.
